// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dmctrl_e;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp
  } lsu_state_e;

  // Access size in bytes; illegal encodings report 4 but are never issued.
  function automatic logic [2:0] size_of(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_BU: size_of = 3'd1;
      DM_H, DM_HU: size_of = 3'd2;
      default:     size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_H, DM_W, DM_BU, DM_HU: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Extracts a byte/half/word from the 64-bit merge buffer at a byte offset and
// sign- or zero-extends it according to the DMCtrl encoding.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] merge_buf_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ctrl_i,
  output logic [31:0] data_o
);

  logic [31:0] win;

  assign win = merge_buf_i[{off_i, 3'b000} +: 32];

  always_comb begin
    data_o = win;
    case (ctrl_i)
      DM_B:    data_o = {{24{win[7]}}, win[7:0]};
      DM_H:    data_o = {{16{win[15]}}, win[15:0]};
      DM_BU:   data_o = {24'h0, win[7:0]};
      DM_HU:   data_o = {16'h0, win[15:0]};
      default: data_o = win;
    endcase
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Multicycle load/store alignment unit: splits word-crossing requests into two
// word-aligned, byte-enabled memory transactions and merges returned data.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [63:0]       merge_q, merge_d;

  logic [1:0]        off;
  logic [2:0]        size;
  logic              split;
  logic [63:0]       lane_data;
  logic [7:0]        mask_base;
  logic [7:0]        lane_mask;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       ext_data;

  assign off       = addr_q[1:0];
  assign size      = size_of(ctrl_q);
  assign split     = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign lane_data = {32'h0, wdata_q} << {off, 3'b000};
  assign mask_base = (8'd1 << size) - 8'd1;
  assign lane_mask = mask_base << off;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  // Second access wraps around the top of the address space.
  assign next_addr = word_addr + ADDR_W'(4);

  lsu_load_extend u_load_extend (
    .merge_buf_i (merge_q),
    .off_i       (off),
    .ctrl_i      (ctrl_q),
    .data_o      (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    ctrl_d     = ctrl_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_wdata  = 32'h0;

    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          ctrl_d  = req_ctrl;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          merge_d = 64'h0;
          state_d = is_legal(req_ctrl) ? StReq0 : StResp;
        end
      end
      StReq0: begin
        mem_req   = 1'b1;
        mem_addr  = word_addr;
        mem_we    = we_q;
        mem_be    = lane_mask[3:0];
        mem_wdata = we_q ? lane_data[31:0] : 32'h0;
        if (mem_ready) state_d = StWait0;
      end
      StWait0: begin
        if (mem_rvalid) begin
          merge_d[31:0] = mem_rdata;
          state_d       = split ? StReq1 : StResp;
        end
      end
      StReq1: begin
        mem_req   = 1'b1;
        mem_addr  = next_addr;
        mem_we    = we_q;
        mem_be    = lane_mask[7:4];
        mem_wdata = we_q ? lane_data[63:32] : 32'h0;
        if (mem_ready) state_d = StWait1;
      end
      StWait1: begin
        if (mem_rvalid) begin
          merge_d[63:32] = mem_rdata;
          state_d        = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = !is_legal(ctrl_q);
        resp_rdata = (we_q || !is_legal(ctrl_q)) ? 32'h0 : ext_data;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      ctrl_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 64'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed, scoreboarded bench for lsu_align_ctrl with a 4-word memory model.
module tb_lsu_align_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        model_rvalid;
  logic        stray_rvalid;
  logic        load_mem;
  logic [31:0] mem [4];

  txn_t  exp_txn_q[$];
  txn_t  act_txn_q[$];
  resp_t exp_resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  lsu_align_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: accepts when mem_req && mem_ready, answers one cycle later.
  always @(posedge clk) begin
    if (load_mem) begin
      mem[0] <= 32'h44332211;
      mem[1] <= 32'h88776655;
      mem[2] <= 32'h0;
      mem[3] <= 32'hDDCCBBAA;
    end
    model_rvalid <= 1'b0;
    if (mem_req && mem_ready) begin
      act_txn_q.push_back(txn_t'{mem_addr, mem_be, mem_we, mem_wdata});
      model_rvalid <= 1'b1;
      mem_rdata    <= mem[mem_addr[3:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr[3:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_rvalid = model_rvalid | stray_rvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_txn(input logic [31:0] addr, input logic [3:0] be, input logic we,
                         input logic [31:0] wdata);
    exp_txn_q.push_back(txn_t'{addr, be, we, wdata});
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int stall);
    int    cyc;
    int    n;
    resp_t e;
    exp_resp_q.push_back(resp_t'{exp_rdata, exp_err, exp_lat});
    check({tag, "_ready_idle"}, req_ready, 1);
    mem_ready = (stall == 0);
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    cyc = 1;
    for (int s = 0; s < stall; s++) begin
      check({tag, "_stall_req"}, mem_req, 1);
      check({tag, "_stall_addr"}, mem_addr, exp_txn_q[0].addr);
      check({tag, "_stall_be"}, mem_be, exp_txn_q[0].be);
      check({tag, "_stall_wdata"}, mem_wdata, exp_txn_q[0].wdata);
      step();
      cyc++;
    end
    mem_ready = 1'b1;
    while (!resp_valid && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, "_resp_seen"}, resp_valid, 1);
    e = exp_resp_q.pop_front();
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, resp_err, e.err);
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_ready_resp"}, req_ready, 0);
    step();
    check({tag, "_resp_pulse"}, resp_valid, 0);
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_txn_count"}, act_txn_q.size(), exp_txn_q.size());
    n = (act_txn_q.size() < exp_txn_q.size()) ? act_txn_q.size() : exp_txn_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_txn_addr"}, act_txn_q[i].addr, exp_txn_q[i].addr);
      check({tag, "_txn_be"}, act_txn_q[i].be, exp_txn_q[i].be);
      check({tag, "_txn_we"}, act_txn_q[i].we, exp_txn_q[i].we);
      if (exp_txn_q[i].we) check({tag, "_txn_wdata"}, act_txn_q[i].wdata, exp_txn_q[i].wdata);
    end
    act_txn_q.delete();
    exp_txn_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_ctrl     = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_ready    = 1'b1;
    stray_rvalid = 1'b0;
    load_mem     = 1'b1;
    step();
    step();
    rst_n    = 1'b1;
    load_mem = 1'b0;

    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);

    exp_txn(32'h0, 4'b1000, 1'b0, 32'h0);
    run_req("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 32'h00000044, 1'b0, 3, 0);
    exp_txn(32'h4, 4'b1000, 1'b0, 32'h0);
    run_req("lb7", 1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0);
    exp_txn(32'h4, 4'b1000, 1'b0, 32'h0);
    run_req("lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0, 3, 0);
    exp_txn(32'h0, 4'b1111, 1'b0, 32'h0);
    run_req("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h44332211, 1'b0, 3, 0);
    exp_txn(32'h0, 4'b1100, 1'b0, 32'h0);
    exp_txn(32'h4, 4'b0011, 1'b0, 32'h0);
    run_req("lw2", 1'b0, 3'b010, 32'h2, 32'h0, 32'h66554433, 1'b0, 5, 0);
    exp_txn(32'h0, 4'b1000, 1'b0, 32'h0);
    exp_txn(32'h4, 4'b0001, 1'b0, 32'h0);
    run_req("lh3", 1'b0, 3'b001, 32'h3, 32'h0, 32'h00005544, 1'b0, 5, 0);
    exp_txn(32'h4, 4'b1100, 1'b0, 32'h0);
    run_req("lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 32'h00008877, 1'b0, 3, 0);
    exp_txn(32'h4, 4'b1100, 1'b0, 32'h0);
    run_req("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8877, 1'b0, 3, 0);
    exp_txn(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0);
    exp_txn(32'h00000000, 4'b0001, 1'b0, 32'h0);
    run_req("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h000011DD, 1'b0, 5, 0);

    run_req("ill011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("ill111_st", 1'b1, 3'b111, 32'h5, 32'h12345678, 32'h0, 1'b1, 1, 0);

    exp_txn(32'h0, 4'b1110, 1'b1, 32'hBBCCDD00);
    exp_txn(32'h4, 4'b0001, 1'b1, 32'h000000AA);
    run_req("sw1", 1'b1, 3'b010, 32'h1, 32'hAABBCCDD, 32'h0, 1'b0, 5, 0);
    exp_txn(32'h0, 4'b1110, 1'b0, 32'h0);
    exp_txn(32'h4, 4'b0001, 1'b0, 32'h0);
    run_req("lw1_rb", 1'b0, 3'b010, 32'h1, 32'h0, 32'hAABBCCDD, 1'b0, 5, 0);

    exp_txn(32'h0, 4'b0100, 1'b1, 32'h00C30000);
    run_req("sb2_stall", 1'b1, 3'b000, 32'h2, 32'h000000C3, 32'h0, 1'b0, 8, 5);
    exp_txn(32'h0, 4'b0100, 1'b0, 32'h0);
    run_req("lb2_rb", 1'b0, 3'b000, 32'h2, 32'h0, 32'hFFFFFFC3, 1'b0, 3, 0);

    // Abandon a split load while waiting for its second word.
    mem_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_ctrl  = 3'b010;
    req_addr  = 32'h2;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_mem_req", mem_req, 0);
    check("mrst_req_ready", req_ready, 1);
    check("mrst_resp_valid", resp_valid, 0);
    stray_rvalid = 1'b1;
    step();
    stray_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_resp_valid", resp_valid, 0);
      check("stray_req_ready", req_ready, 1);
      step();
    end
    act_txn_q.delete();

    exp_txn(32'h0, 4'b1111, 1'b0, 32'h0);
    run_req("lw0_after", 1'b0, 3'b010, 32'h0, 32'h0, 32'hBBC3DD11, 1'b0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_align_ctrl.md
Name: lsu_align_ctrl

Overview:
Multicycle load/store alignment unit placed between the core's execute stage and a word-organised data memory. Takes byte/half/word requests with the existing 3-bit DMCtrl encoding and byte address, and issues word-aligned, byte-enabled memory transactions. Requests that cross a word boundary are split into two transactions. Returned words are merged and sign/zero-extended into the load result.

Parameters:
ADDR_W, 32, byte address width; memory address output is always 4-byte aligned.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  core request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_ctrl  in  3  DMCtrl: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse (loads and stores)
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal req_ctrl, valid with resp_valid
mem_req  out  1  memory transaction valid
mem_ready  in  1  memory accepts transaction when mem_req && mem_ready
mem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0)
mem_we  out  1  write transaction
mem_be  out  4  byte enables
mem_wdata  out  32  write data, lane-aligned
mem_rvalid  in  1  completion of accepted transaction (read data or write ack)
mem_rdata  in  32  read word, valid with mem_rvalid

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err all 0; captured request and 64-bit merge buffer cleared. req_ready = 1 in the first cycle after reset. Reset mid-transaction abandons it; late mem_rvalid in IDLE is ignored.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid capture we/ctrl/addr/wdata. Illegal ctrl -> RESP with err=1, no memory access. Else -> REQ0.
- Size = 1/2/4 bytes from ctrl[1:0]; off = addr[1:0]; split = (off + size > 4).
- Store lanes: 64-bit data = wdata << (8*off); 8-bit mask = ((1<<size)-1) << off. Access 0 uses low 32 bits/low 4 mask bits at addr & ~3; access 1 uses high halves at (addr & ~3) + 4 (wraps modulo 2^ADDR_W).
- REQ0: mem_req=1 with access-0 fields; hold stable until mem_ready -> WAIT0. REQ1 same with access-1 fields -> WAIT1.
- WAIT0: on mem_rvalid store mem_rdata to buffer[31:0]; -> REQ1 if split else RESP. WAIT1: on mem_rvalid store to buffer[63:32] -> RESP.
- Loads: mem_be = same mask as stores (informational), mem_we=0.
- RESP: resp_valid=1 for exactly one cycle; load data = (buffer >> 8*off)[31:0] truncated to size, then sign-extend (000/001) or zero-extend (100/101); -> IDLE. req_ready low in all non-IDLE states, including RESP.
- Only one outstanding memory transaction; mem_rvalid outside WAIT0/WAIT1 ignored.
- Latency, aligned, mem_ready=1, rvalid one cycle after acceptance: accept at cycle 0, mem_req cycle 1, rvalid cycle 2, resp_valid cycle 3. Split adds 2 cycles. Illegal: resp_valid at cycle 1.

Decomposition:
- Shared package lsu_pkg: dmctrl_e enum (DM_B=000, DM_H=001, DM_W=010, DM_BU=100, DM_HU=101), lsu_state_e, function size_of(ctrl), function is_legal(ctrl).
- One sub-module, lsu_load_extend: combinational shift/truncate/extend of the 64-bit buffer by off and ctrl. It is reusable by the single-cycle datapath.

Test Plan:
- Memory word0=0x44332211, word1=0x88776655. LB @3 -> rdata 0x00000044. LB @7 -> 0xFFFFFF88. LBU @7 -> 0x00000088. Each uses one access, mem_be 1000.
- LW @2 -> two accesses at 0x0 (be 1100) and 0x4 (be 0011); rdata 0x66554433; resp_valid at cycle 5.
- LH @3 -> split, rdata 0x00005544. LHU @6 -> single access, rdata 0x00008877. LH @6 -> 0xFFFF8877.
- SW @1 wdata 0xAABBCCDD -> access0 addr 0x0 be 1110 wdata 0xBBCCDD00, access1 addr 0x4 be 0001 wdata 0x000000AA; resp_rdata 0.
- req_ctrl=011 -> resp_valid next cycle with resp_err=1, rdata 0, mem_req never asserted. mem_ready held low 5 cycles in REQ0 -> mem_addr/be/wdata stable throughout.
- rst_n low during WAIT1 of split LW -> next cycle mem_req 0, req_ready 1, resp_valid 0; a stray mem_rvalid afterwards causes no response.
